inst_axi_rd_bridge: RTL
=======================

Name: inst_axi_rd_bridge

Overview:
- Sits directly upstream of if_stage.
- Converts the instruction-side SRAM-like interface (inst_sram_en/addr/addr_ok/data_ok/rdata) into a single-beat AXI4 read channel.
- Supports up to two outstanding fetches, in order, so the IF stage can issue the next address before the current data returns.
- Write-side inst_sram_wen/wdata are ignored (always zero from IF); the bridge has no write channel.

Parameters:
- ARID_VAL, 4'd0, constant value driven on arid for all instruction reads.
- MAX_OUTST, 2, maximum number of accepted-but-unreturned requests (legal values 1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- inst_sram_en  in  1  fetch request valid
- inst_sram_addr  in  32  fetch address (physical)
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  fetch data valid this cycle
- inst_sram_rdata  out  32  fetch data
- arid  out  4  AXI read ID
- araddr  out  32  AXI read address
- arlen  out  8  burst length, constant 0
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R ID (ignored; responses arrive in order)
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last (ignored; every read is a single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: arvalid=0, araddr=0, outst_cnt=0, ar_st=AR_IDLE. All outputs deasserted: addr_ok, data_ok and rready are 0.
- AR FSM states:
  - AR_IDLE: arvalid=0.
  - AR_SEND: arvalid=1, araddr held stable.
- AR_IDLE -> AR_SEND when (inst_sram_en && outst_cnt<MAX_OUTST). On that cycle inst_sram_addr_ok=1 combinationally and araddr<=inst_sram_addr.
- AR_SEND -> AR_IDLE on arvalid&&arready. No new address is accepted while in AR_SEND, so addr_ok=0.
- Minimum address-to-address spacing is therefore 2 cycles with arready=1.
- outst_cnt (2 bits) counts accepted requests not yet returned:
  - +1 on inst_sram_addr_ok.
  - -1 on rvalid&&rready.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST; never underflows. An R beat with outst_cnt==0 is a protocol error: rready stays 0, so it is never consumed.
- rready = (outst_cnt!=0).
- inst_sram_data_ok = rvalid && rready, combinational, same cycle as the R handshake.
- inst_sram_rdata = rdata passthrough. Downstream must capture data on the data_ok cycle; if_stage latches it internally.
- Latency with arready=1 and a 1-cycle slave:
  - addr_ok at cycle T.
  - arvalid at T+1.
  - data_ok at T+2 at the earliest.
- rresp != OKAY: data is still returned with data_ok=1. Error reporting is out of scope and the value is not recorded.
- inst_sram_en dropping while in AR_SEND does not cancel the request. Once addr_ok has been given, the read is always completed and returned.
- Data is returned in acceptance order. There are no flush or cancel inputs; discarding unwanted returned instructions is the IF stage's responsibility.
- Reset mid-operation: all state clears in one cycle. The AXI slave is reset by the same signal, so no in-flight beats survive.

Decomposition:
- Shared package (mycpu.h): AXI constants AXI_LEN_1BEAT=8'd0, AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AR FSM state encodings.
- Single flat module; no sub-module. The data-side bridge will reuse the same constants later.

Test Plan:
- Single fetch: en=1, addr=0xbfc00000 -> addr_ok at T, arvalid/araddr=0xbfc00000 at T+1. Slave returns 0x3c1d0001 at T+3 -> data_ok=1, rdata=0x3c1d0001, outst_cnt back to 0.
- Two outstanding: addrs 0xbfc00000 and 0xbfc00004 accepted back-to-back, responses withheld -> a third en is held with addr_ok=0 until the first R handshake; data returned in order.
- arready low for 5 cycles -> arvalid stays 1, araddr stable, addr_ok=0 throughout; transfer completes on the first arready=1 cycle.
- Simultaneous addr_ok and R handshake with outst_cnt=1 -> outst_cnt stays 1; data_ok=1 the same cycle.
- rresp=2'b10 on a return -> data_ok still 1 with rdata passed through; outst_cnt decrements.
- reset asserted while outst_cnt=2 and in AR_SEND -> next cycle arvalid=0, outst_cnt=0, rready=0, addr_ok=0.

Source files
------------

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-channel constants and AR FSM encoding for the instruction/data bridges.
package inst_axi_rd_bridge_pkg;

  localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    ArIdle = 1'b0,
    ArSend = 1'b1
  } ar_st_e;

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// Instruction SRAM-like request side plus single-beat AXI4 read channel.
interface inst_axi_rd_bridge_if;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Bridge side
  modport master (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // IF stage and AXI slave side
  modport slave (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: SRAM-like requests to in-order single-beat AXI reads,
// with up to MAX_OUTST accepted-but-unreturned fetches.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0]  ARID_VAL  = 4'd0,
  parameter int unsigned MAX_OUTST = 2
) (
  input logic                  clk,
  input logic                  reset,
  inst_axi_rd_bridge_if.master bus
);

  localparam logic [1:0] MaxCnt = 2'(MAX_OUTST);

  ar_st_e      ar_st_q, ar_st_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  outst_cnt_q, outst_cnt_d;
  logic        addr_ok;
  logic        r_hs;
  logic        rready;

  always_comb begin
    // Gated by reset so nothing is accepted while state is being cleared
    addr_ok     = !reset && (ar_st_q == ArIdle) && bus.inst_sram_en && (outst_cnt_q < MaxCnt);
    rready      = (outst_cnt_q != 2'd0);
    r_hs        = bus.rvalid && rready;
    ar_st_d     = ar_st_q;
    araddr_d    = araddr_q;
    outst_cnt_d = outst_cnt_q;

    unique case (ar_st_q)
      ArIdle: begin
        if (addr_ok) begin
          ar_st_d  = ArSend;
          araddr_d = bus.inst_sram_addr;
        end
      end
      ArSend: begin
        if (bus.arready) ar_st_d = ArIdle;
      end
      default: ar_st_d = ArIdle;
    endcase

    unique case ({addr_ok, r_hs})
      2'b10:   outst_cnt_d = outst_cnt_q + 2'd1;
      2'b01:   outst_cnt_d = outst_cnt_q - 2'd1;
      default: outst_cnt_d = outst_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_st_q     <= ArIdle;
      araddr_q    <= '0;
      outst_cnt_q <= '0;
    end else begin
      ar_st_q     <= ar_st_d;
      araddr_q    <= araddr_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = r_hs;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.arid              = ARID_VAL;
  assign bus.araddr            = araddr_q;
  assign bus.arlen             = AXI_LEN_1BEAT;
  assign bus.arsize            = AXI_SIZE_4B;
  assign bus.arburst           = AXI_BURST_INCR;
  assign bus.arvalid           = (ar_st_q == ArSend);
  assign bus.rready            = rready;

  // Responses are in order and single-beat; the error response is not recorded
  logic unused_rsigs;
  assign unused_rsigs = ^{bus.rid, bus.rlast, bus.rresp};

endmodule
